// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle for the two requester ports and the shared memory bus.
// The arbiter uses the slave modport; the requester/memory side uses master.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  i_req_valid;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic                  i_req_ready;
  logic                  i_rsp_valid;
  logic [DATA_WIDTH-1:0] i_rsp_rdata;
  logic                  i_rsp_err;

  logic                  d_req_valid;
  logic                  d_req_we;
  logic [ADDR_WIDTH-1:0] d_req_addr;
  logic [DATA_WIDTH-1:0] d_req_wdata;
  logic                  d_req_ready;
  logic                  d_rsp_valid;
  logic [DATA_WIDTH-1:0] d_rsp_rdata;
  logic                  d_rsp_err;

  logic                  mem_cs;
  logic                  mem_oe;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport slave (
    input  i_req_valid, i_req_addr, d_req_valid, d_req_we, d_req_addr, d_req_wdata, mem_dout,
    output i_req_ready, i_rsp_valid, i_rsp_rdata, i_rsp_err,
    output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
    output mem_cs, mem_oe, mem_we, mem_addr, mem_din
  );

  modport master (
    output i_req_valid, i_req_addr, d_req_valid, d_req_we, d_req_addr, d_req_wdata, mem_dout,
    input  i_req_ready, i_rsp_valid, i_rsp_rdata, i_rsp_err,
    input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
    input  mem_cs, mem_oe, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port memory between an
// instruction-fetch port (read-only) and a data port; one transaction in flight.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

  state_e                state_q, state_d;
  logic                  last_d_q, last_d_d;    // 1: port D held the most recent grant
  logic                  owner_d_q, owner_d_d;
  logic                  is_read_q, is_read_d;
  logic                  mem_cs_q, mem_cs_d;
  logic                  mem_oe_q, mem_oe_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
  logic                  i_rsp_valid_q, i_rsp_valid_d;
  logic                  i_rsp_err_q, i_rsp_err_d;
  logic [DATA_WIDTH-1:0] i_rsp_rdata_q, i_rsp_rdata_d;
  logic                  d_rsp_valid_q, d_rsp_valid_d;
  logic                  d_rsp_err_q, d_rsp_err_d;
  logic [DATA_WIDTH-1:0] d_rsp_rdata_q, d_rsp_rdata_d;

  logic                  grant_i, grant_d;
  logic                  sel_we, misaligned;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  always_comb begin
    state_d       = state_q;
    last_d_d      = last_d_q;
    owner_d_d     = owner_d_q;
    is_read_d     = is_read_q;
    mem_cs_d      = 1'b0;
    mem_oe_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_din_d     = mem_din_q;
    i_rsp_valid_d = 1'b0;
    i_rsp_err_d   = 1'b0;
    i_rsp_rdata_d = i_rsp_rdata_q;
    d_rsp_valid_d = 1'b0;
    d_rsp_err_d   = 1'b0;
    d_rsp_rdata_d = d_rsp_rdata_q;
    grant_i       = 1'b0;
    grant_d       = 1'b0;

    if (state_q == StIdle) begin
      grant_i = bus.i_req_valid && (!bus.d_req_valid || last_d_q);
      grant_d = bus.d_req_valid && !grant_i;
    end
    sel_addr   = grant_d ? bus.d_req_addr : bus.i_req_addr;
    sel_we     = grant_d && bus.d_req_we;
    sel_wdata  = grant_d ? bus.d_req_wdata : '0;
    misaligned = CHECK_ALIGN && (sel_addr[1:0] != 2'b00);

    unique case (state_q)
      StIdle: begin
        if (grant_i || grant_d) begin
          last_d_d = grant_d;
          if (misaligned) begin
            // Rejected without touching memory; rdata is left as it was.
            i_rsp_valid_d = grant_i;
            i_rsp_err_d   = grant_i;
            d_rsp_valid_d = grant_d;
            d_rsp_err_d   = grant_d;
          end else begin
            mem_cs_d   = 1'b1;
            mem_oe_d   = !sel_we;
            mem_we_d   = sel_we;
            mem_addr_d = sel_addr;
            mem_din_d  = sel_wdata;
            owner_d_d  = grant_d;
            is_read_d  = !sel_we;
            state_d    = StIssue;
          end
        end
      end
      StIssue: state_d = StCapture;
      StCapture: begin
        if (owner_d_q) begin
          d_rsp_valid_d = 1'b1;
          if (is_read_q) d_rsp_rdata_d = bus.mem_dout;
        end else begin
          i_rsp_valid_d = 1'b1;
          if (is_read_q) i_rsp_rdata_d = bus.mem_dout;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      last_d_q      <= 1'b1;
      owner_d_q     <= 1'b0;
      is_read_q     <= 1'b0;
      mem_cs_q      <= 1'b0;
      mem_oe_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      i_rsp_valid_q <= 1'b0;
      i_rsp_err_q   <= 1'b0;
      i_rsp_rdata_q <= '0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_err_q   <= 1'b0;
      d_rsp_rdata_q <= '0;
    end else begin
      state_q       <= state_d;
      last_d_q      <= last_d_d;
      owner_d_q     <= owner_d_d;
      is_read_q     <= is_read_d;
      mem_cs_q      <= mem_cs_d;
      mem_oe_q      <= mem_oe_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
      i_rsp_valid_q <= i_rsp_valid_d;
      i_rsp_err_q   <= i_rsp_err_d;
      i_rsp_rdata_q <= i_rsp_rdata_d;
      d_rsp_valid_q <= d_rsp_valid_d;
      d_rsp_err_q   <= d_rsp_err_d;
      d_rsp_rdata_q <= d_rsp_rdata_d;
    end
  end

  assign bus.i_req_ready = grant_i;
  assign bus.d_req_ready = grant_d;
  assign bus.i_rsp_valid = i_rsp_valid_q;
  assign bus.i_rsp_err   = i_rsp_err_q;
  assign bus.i_rsp_rdata = i_rsp_rdata_q;
  assign bus.d_rsp_valid = d_rsp_valid_q;
  assign bus.d_rsp_err   = d_rsp_err_q;
  assign bus.d_rsp_rdata = d_rsp_rdata_q;
  assign bus.mem_cs      = mem_cs_q;
  assign bus.mem_oe      = mem_oe_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_din     = mem_din_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level model of grants, memory and responses.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CHECK_ALIGN(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endfunction

  function automatic logic [31:0] init_word(input int idx);
    logic [31:0] a;
    a = 32'(idx) << 2;
    return (idx == 0) ? 32'h8C01_0004 : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Memory attached to the DUT: registered dout, 64 words.
  logic [31:0] phys [0:63];
  always @(posedge clk) begin
    if (bus.mem_cs) begin
      if (bus.mem_we) phys[bus.mem_addr[7:2]] <= bus.mem_din;
      if (bus.mem_oe) bus.mem_dout <= phys[bus.mem_addr[7:2]];
    end
  end

  // Reference model state.
  typedef struct {
    bit          port_d;
    bit          err;
    logic [31:0] rdata;
    int          due;
  } rsp_t;
  rsp_t        sbq[$];
  logic [31:0] ref_mem [0:63];
  int          free_at;
  bit          last_d;
  logic [31:0] mrd_i, mrd_d, vis_i, vis_d;
  bit          mchk;
  int          mchk_cyc;
  logic        mchk_oe, mchk_we;
  logic [31:0] mchk_addr, mchk_din;

  task automatic model_reset();
    sbq.delete();
    free_at = 0;
    last_d  = 1'b1;
    mrd_i   = '0;
    mrd_d   = '0;
    vis_i   = '0;
    vis_d   = '0;
    mchk    = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin : mon
      bit          ei, ed, w;
      logic [31:0] a, wd;
      rsp_t        e;

      if (mchk && mchk_cyc == cyc) begin
        chk("mem_cs", 32'(bus.mem_cs), 32'd1);
        chk("mem_oe", 32'(bus.mem_oe), 32'(mchk_oe));
        chk("mem_we", 32'(bus.mem_we), 32'(mchk_we));
        chk("mem_addr", bus.mem_addr, mchk_addr);
        chk("mem_din", bus.mem_din, mchk_din);
        mchk = 1'b0;
      end else begin
        chk("mem_cs_idle", 32'(bus.mem_cs), 32'd0);
        chk("mem_we_idle", 32'(bus.mem_we), 32'd0);
      end

      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        chk("i_rsp_valid", 32'(bus.i_rsp_valid), 32'(!e.port_d));
        chk("d_rsp_valid", 32'(bus.d_rsp_valid), 32'(e.port_d));
        if (e.port_d) begin
          chk("d_rsp_err", 32'(bus.d_rsp_err), 32'(e.err));
          vis_d = e.rdata;
        end else begin
          chk("i_rsp_err", 32'(bus.i_rsp_err), 32'(e.err));
          vis_i = e.rdata;
        end
      end else begin
        chk("i_rsp_unexpected", 32'(bus.i_rsp_valid), 32'd0);
        chk("d_rsp_unexpected", 32'(bus.d_rsp_valid), 32'd0);
      end
      chk("i_rsp_rdata", bus.i_rsp_rdata, vis_i);
      chk("d_rsp_rdata", bus.d_rsp_rdata, vis_d);

      // Grant rule: free arbiter, lone requester wins, tie goes to the port not granted last.
      ei = 1'b0;
      ed = 1'b0;
      if (cyc >= free_at) begin
        ei = bus.i_req_valid && (!bus.d_req_valid || last_d);
        ed = bus.d_req_valid && !ei;
      end
      chk("i_req_ready", 32'(bus.i_req_ready), 32'(ei));
      chk("d_req_ready", 32'(bus.d_req_ready), 32'(ed));

      if (ei || ed) begin
        a      = ed ? bus.d_req_addr : bus.i_req_addr;
        w      = ed && bus.d_req_we;
        wd     = ed ? bus.d_req_wdata : 32'd0;
        last_d = ed;
        e.port_d = ed;
        if (a[1:0] != 2'b00) begin
          e.err   = 1'b1;
          e.rdata = ed ? mrd_d : mrd_i;
          e.due   = cyc + 1;
          free_at = cyc + 1;
        end else begin
          mchk      = 1'b1;
          mchk_cyc  = cyc + 1;
          mchk_oe   = !w;
          mchk_we   = w;
          mchk_addr = a;
          mchk_din  = wd;
          if (w) ref_mem[a[7:2]] = wd;
          else if (ed) mrd_d = ref_mem[a[7:2]];
          else mrd_i = ref_mem[a[7:2]];
          e.err   = 1'b0;
          e.rdata = ed ? mrd_d : mrd_i;
          e.due   = cyc + 3;
          free_at = cyc + 3;
        end
        sbq.push_back(e);
      end
    end
  end

  task automatic do_i(input logic [31:0] a);
    bit got;
    got = 1'b0;
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = a;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = bus.i_req_ready;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL i_accept_timeout: got no ready expected ready (addr %h)", a);
    end
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
  endtask

  task automatic do_d(input bit we, input logic [31:0] a, input logic [31:0] wd);
    bit got;
    got = 1'b0;
    bus.d_req_valid = 1'b1;
    bus.d_req_we    = we;
    bus.d_req_addr  = a;
    bus.d_req_wdata = wd;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = bus.d_req_ready;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL d_accept_timeout: got no ready expected ready (addr %h)", a);
    end
    @(posedge clk);
    #1;
    bus.d_req_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 63)) << 2;
    if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
    return a;
  endfunction

  task automatic idle_gap();
    int gap;
    gap = $urandom_range(0, 3);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_i(input int n);
    for (int j = 0; j < n; j++) begin
      idle_gap();
      do_i(rand_addr());
    end
  endtask

  task automatic rand_d(input int n);
    for (int j = 0; j < n; j++) begin
      idle_gap();
      do_d(1'($urandom_range(0, 1)), rand_addr(), $urandom);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_mem_cs", 32'(bus.mem_cs), 32'd0);
    chk("rst_mem_oe", 32'(bus.mem_oe), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_din", bus.mem_din, 32'd0);
    chk("rst_i_rsp", {29'd0, bus.i_rsp_valid, bus.i_rsp_err, 1'b0}, 32'd0);
    chk("rst_d_rsp", {29'd0, bus.d_rsp_valid, bus.d_rsp_err, 1'b0}, 32'd0);
    chk("rst_i_rdata", bus.i_rsp_rdata, 32'd0);
    chk("rst_d_rdata", bus.d_rsp_rdata, 32'd0);
  endtask

  // Reset is asserted just after a rising edge; outputs must clear at once.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sbq.size() > 0; k++) @(posedge clk);
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d responses outstanding expected 0", sbq.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req_valid = 1'b0;
    bus.i_req_addr  = '0;
    bus.d_req_valid = 1'b0;
    bus.d_req_we    = 1'b0;
    bus.d_req_addr  = '0;
    bus.d_req_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      phys[i]    = init_word(i);
      ref_mem[i] = init_word(i);
    end
    model_reset();
    @(posedge clk);
    #1;
    apply_reset();

    // Single read of address 0.
    do_i(32'h0);
    drain();
    chk("first_read_rdata", bus.i_rsp_rdata, 32'h8C01_0004);

    // Write then read back on D; write leaves d_rsp_rdata unchanged.
    do_d(1'b1, 32'h10, 32'hDEAD_BEEF);
    drain();
    do_d(1'b0, 32'h10, 32'h0);
    drain();
    chk("d_readback", bus.d_rsp_rdata, 32'hDEAD_BEEF);

    // Misaligned D request is rejected without a memory access.
    do_d(1'b0, 32'h13, 32'h0);
    drain();

    // Both ports continuously requesting from reset.
    @(posedge clk);
    #1;
    apply_reset();
    fork
      for (int j = 0; j < 4; j++) do_i(32'(j) << 2);
      for (int j = 0; j < 4; j++) do_d(1'b0, 32'h40 + (32'(j) << 2), 32'h0);
    join
    drain();

    // Reset while a read sits in ISSUE: no response and no access afterwards.
    do_i(32'h20);
    apply_reset();
    repeat (6) @(posedge clk);
    #1;
    do_i(32'h0);
    drain();

    // Lone D requester issuing back to back.
    for (int j = 0; j < 3; j++) do_d(1'b0, 32'h80 + (32'(j) << 2), 32'h0);
    drain();

    fork
      rand_i(40);
      rand_d(40);
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
